// File: rtl/data_mem_responder_if.sv
// Purpose : request/response bundle between a datapath (master) and the data memory responder (slave).
// Latency : n/a (wires only).
// Backpressure: master holds req_* stable while req_valid && !req_ready; response is a one-cycle strobe with no stall.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept this cycle
//   req_we     master->slave  1 = store word, 0 = load word
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data
//   resp_valid slave->master  one-cycle response strobe
//   resp_rdata slave->master  load data, 0 for stores/faults/idle
//   resp_err   slave->master  request faulted, qualified by resp_valid
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose : single-outstanding word-wide data memory that answers load/store requests from a datapath.
// Latency : LATENCY+1 cycles from accept to the one-cycle resp_valid strobe.
// Backpressure: req_ready only in IDLE; requests presented while busy are neither queued nor accepted.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   reset    - synchronous active-low reset (storage contents are kept)
//   mem_bus  - data_mem_responder_if.slave (req_valid/ready/we/addr/wdata, resp_valid/rdata/err)
//
// Parameters:
//   BASE_ADDR   - byte address of word 0
//   DEPTH_WORDS - number of 32-bit storage words
//   LATENCY     - wait cycles between accept and response, 0..15
//
// Build option:
//   DMEM_MISALIGN_CHECK_EN - when defined, any address with addr[1:0] != 0 faults;
//                            when undefined, addr[1:0] is ignored and alignment never faults.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   mem_bus
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Span kept 33 bits wide so BASE_ADDR + span can never wrap in the range test.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam bit          ZERO_LAT   = (LATENCY == 0);
    localparam logic [3:0]  LAT_M1     = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic         w_enter_resp;

    // Latched request; only meaningful after an accept.
    logic         r_we;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;

    // Registered response payload, non-zero only during the RESP cycle.
    logic         r_resp_err;
    logic [31:0]  r_resp_rdata;

    logic [31:0]  r_mem [DEPTH_WORDS];

    logic         w_req_ready;
    logic         w_accept;
    logic         w_cur_we;
    logic [31:0]  w_cur_addr;
    logic [31:0]  w_cur_wdata;
    logic [31:0]  w_off;
    logic         w_below;
    logic         w_above;
    logic         w_misalign;
    logic         w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]  w_rd_word;
    logic         w_commit;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Gating with reset keeps ready low for the whole reset window and
    // lets it rise in the first cycle after release.
    assign w_req_ready = (r_state == IDLE) && reset;
    assign w_accept    = mem_bus.req_valid && w_req_ready;

    // ------------------------------------------------------------------
    // Request view used at the edge that enters RESP.
    // With LATENCY==0 that edge is the accept edge itself, so the live
    // inputs are used; otherwise the latched copy is used, which makes
    // input changes after accept irrelevant.
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_we    = r_we;
        w_cur_addr  = r_addr;
        w_cur_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_cur_we    = mem_bus.req_we;
            w_cur_addr  = mem_bus.req_addr;
            w_cur_wdata = mem_bus.req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Offset is a plain 32-bit unsigned subtraction; the explicit
    // below-base test stops low addresses from wrapping into range.
    assign w_off   = w_cur_addr - BASE_ADDR;
    assign w_below = (w_cur_addr < BASE_ADDR);
    assign w_above = ({1'b0, w_off} >= SPAN_BYTES);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = (w_cur_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err     = w_below || w_above || w_misalign;
    assign w_idx     = w_off[IDX_W+1:2];
    // Storage is only read for in-range addresses, so the index is never
    // outside the array when the word is actually used.
    assign w_rd_word = w_err ? 32'd0 : r_mem[w_idx];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (ZERO_LAT) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_resp) begin
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_cur_we || w_err) ? 32'd0 : w_rd_word;
            end else begin
                // Payload is cleared on every other edge so it reads zero
                // whenever resp_valid is low.
                r_resp_err   <= 1'b0;
                r_resp_rdata <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request capture (datapath register, no reset needed: it is only
    // consumed after an accept, and accept is blocked during reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= mem_bus.req_we;
            r_addr  <= mem_bus.req_addr;
            r_wdata <= mem_bus.req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Storage: never reset. A store commits on the edge entering RESP;
    // a reset in flight prevents that edge from ever happening, so the
    // aborted store is dropped.
    // ------------------------------------------------------------------
    assign w_commit = reset && w_enter_resp && w_cur_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_cur_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_bus.req_ready  = w_req_ready;
    assign mem_bus.resp_valid = (r_state == RESP);
    assign mem_bus.resp_rdata = r_resp_rdata;
    assign mem_bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : self-checking bench for data_mem_responder (LATENCY=2 and LATENCY=0 instances).
// Latency : n/a.
// Backpressure: bench drives req_valid and waits (bounded) for req_ready.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          NV    = 13;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst2;
    logic rst0;

    always #5 clk = ~clk;

    data_mem_responder_if b2();
    data_mem_responder_if b0();

    data_mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (2)
    ) u_dut (
        .clk     (clk),
        .reset   (rst2),
        .mem_bus (b2)
    );

    data_mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (0)
    ) u_dut0 (
        .clk     (clk),
        .reset   (rst0),
        .mem_bus (b0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory for the LATENCY=2 instance.
    logic [31:0] mdl [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Behavioural model: address arithmetic done in 64 bits straight from
    // the address-map rules, so nothing can wrap.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic er);
        longint unsigned a;
        longint unsigned idx;
        bit bad;
        a   = 64'(addr);
        bad = (a < 64'(BASE)) || (a >= 64'(BASE) + 64'(4 * DEPTH));
        if (MIS && (a % 4 != 0)) bad = 1'b1;
        if (bad) begin
            rd = 32'd0;
            er = 1'b1;
        end else begin
            idx = (a - 64'(BASE)) / 4;
            er  = 1'b0;
            if (we) begin
                mdl[idx] = wdata;
                rd       = 32'd0;
            end else begin
                rd = mdl[idx];
            end
        end
    endfunction

    // One transaction on the LATENCY=2 instance. Called just after a
    // rising edge with the DUT idle. After accept the request inputs are
    // scrambled so the response must come from the latched request.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        b2.req_valid = 1'b1;
        b2.req_we    = we;
        b2.req_addr  = addr;
        b2.req_wdata = wdata;
        @(negedge clk);
        chk("ready_when_idle", b2.req_ready, 1'b1);
        guard = 0;
        while (b2.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (b2.req_ready !== 1'b1) fail_bound("accept_wait");
        @(posedge clk);
        #1;
        b2.req_valid = 1'b0;
        b2.req_we    = 1'($urandom_range(0, 1));
        b2.req_addr  = $urandom;
        b2.req_wdata = $urandom;
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (b2.resp_valid === 1'b1) break;
            chk("idle_rdata_zero", b2.resp_rdata, 32'd0);
            chk("idle_err_zero", {31'd0, b2.resp_err}, 32'd0);
            chk("busy_ready_low", {31'd0, b2.req_ready}, 32'd0);
        end
        if (b2.resp_valid === 1'b1) begin
            rdata = b2.resp_rdata;
            err   = b2.resp_err;
        end else begin
            fail_bound("resp_wait");
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [NV];

    // Watchdog: stop cleanly if something hangs.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, wd, ad, old;
        logic        er, eer, we;
        int          lat, kind, k;
        logic        acc;
        logic [31:0] s_addr [6];
        logic [31:0] s_wd   [6];
        logic [31:0] s_exp  [6];
        logic        s_we   [6];

        tbl[0]  = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 32'h1000_FFFC, 32'h0,         32'h0, 1'b1};
        tbl[3]  = '{1'b0, 32'h1001_1000, 32'h0,         32'h0, 1'b1};
        tbl[4]  = '{1'b1, 32'h1001_0FFC, 32'h55AA_55AA, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h1001_0FFC, 32'h0,         32'h55AA_55AA, 1'b0};
        tbl[6]  = '{1'b1, 32'h1001_0000, 32'h0BAD_F00D, 32'h0, 1'b0};
        tbl[7]  = '{1'b1, 32'h1001_0002, 32'h1234_5678, 32'h0, MIS};
        tbl[8]  = '{1'b0, 32'h1001_0000, 32'h0,         MIS ? 32'h0BAD_F00D : 32'h1234_5678, 1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0, 1'b1};
        tbl[10] = '{1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 32'h1001_0020, 32'hA5A5_A5A5, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 32'h1001_0020, 32'h0,         32'hA5A5_A5A5, 1'b0};

        s_we[0] = 1'b1; s_addr[0] = 32'h1001_0000; s_wd[0] = 32'h1111_1111; s_exp[0] = 32'h0;
        s_we[1] = 1'b1; s_addr[1] = 32'h1001_0004; s_wd[1] = 32'h2222_2222; s_exp[1] = 32'h0;
        s_we[2] = 1'b1; s_addr[2] = 32'h1001_0FFC; s_wd[2] = 32'h3333_3333; s_exp[2] = 32'h0;
        s_we[3] = 1'b0; s_addr[3] = 32'h1001_0004; s_wd[3] = 32'h0;         s_exp[3] = 32'h2222_2222;
        s_we[4] = 1'b0; s_addr[4] = 32'h1001_0000; s_wd[4] = 32'h0;         s_exp[4] = 32'h1111_1111;
        s_we[5] = 1'b0; s_addr[5] = 32'h1001_0FFC; s_wd[5] = 32'h0;         s_exp[5] = 32'h3333_3333;

        rst2 = 1'b0;
        rst0 = 1'b0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 32'd0; b2.req_wdata = 32'd0;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'd0; b0.req_wdata = 32'd0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, b2.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, b2.resp_valid}, 32'd0);
        chk("rst_rdata", b2.resp_rdata, 32'd0);
        chk("rst_err", {31'd0, b2.resp_err}, 32'd0);
        chk("rst_ready_l0", {31'd0, b0.req_ready}, 32'd0);
        chk("rst_resp_valid_l0", {31'd0, b0.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        rst0 = 1'b1;
        @(negedge clk);
        chk("ready_after_release", b2.req_ready, 1'b1);
        chk("ready_after_release_l0", b0.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // ---------------- fill every word with random data ----------------
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            ad = BASE + 32'(4 * i);
            model(1'b1, ad, wd, erd, eer);
            txn(1'b1, ad, wd, rd, er, lat);
            chk("fill_err", {31'd0, er}, 32'd0);
        end

        // ---------------- directed vectors ----------------
        for (int i = 0; i < NV; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, erd, eer);
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // ---------------- randomized against model ----------------
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5)      ad = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (kind == 6) ad = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (kind == 7) ad = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                                 : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 12));
            else if (kind == 8) ad = $urandom;
            else                ad = BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            model(we, ad, wd, erd, eer);
            txn(we, ad, wd, rd, er, lat);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", {31'd0, er}, {31'd0, eer});
            chk("rnd_latency", 32'(lat), 32'd3);
        end

        // ---------------- reset during WAIT aborts a store ----------------
        old = mdl[4];
        b2.req_valid = 1'b1;
        b2.req_we    = 1'b1;
        b2.req_addr  = 32'h1001_0010;
        b2.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("abort_accept_ready", b2.req_ready, 1'b1);
        @(posedge clk);
        #1;
        b2.req_valid = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("abort_rst_ready", {31'd0, b2.req_ready}, 32'd0);
        chk("abort_rst_resp_valid", {31'd0, b2.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("abort_ready_c%0d", c), b2.req_ready, 1'b1);
            chk($sformatf("abort_no_resp_c%0d", c), {31'd0, b2.resp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        txn(1'b0, 32'h1001_0010, 32'h0, rd, er, lat);
        chk("abort_load_prior", rd, old);
        chk("abort_load_err", {31'd0, er}, 32'd0);

        // ---------------- LATENCY=0, req_valid held high ----------------
        k = 0;
        b0.req_valid = 1'b1;
        b0.req_we    = s_we[0];
        b0.req_addr  = s_addr[0];
        b0.req_wdata = s_wd[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("l0_ready_c%0d", c), {31'd0, b0.req_ready}, {31'd0, (c % 2 == 0)});
            chk($sformatf("l0_resp_valid_c%0d", c), {31'd0, b0.resp_valid}, {31'd0, (c % 2 == 1)});
            if (c % 2 == 1) begin
                chk($sformatf("l0_rdata_c%0d", c), b0.resp_rdata, s_exp[(c - 1) / 2]);
                chk($sformatf("l0_err_c%0d", c), {31'd0, b0.resp_err}, 32'd0);
            end
            acc = b0.req_ready;
            @(posedge clk);
            #1;
            if (acc === 1'b1) begin
                k++;
                if (k < 6) begin
                    b0.req_we    = s_we[k];
                    b0.req_addr  = s_addr[k];
                    b0.req_wdata = s_wd[k];
                end else begin
                    b0.req_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("l0_final_ready", b0.req_ready, 1'b1);
        chk("l0_final_resp_valid", {31'd0, b0.resp_valid}, 32'd0);
        chk("l0_accept_count", 32'(k), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
